axi4_lite_rd_arbiter: RTL and testbench

Two-to-one AXI4-Lite read-channel arbiter that lets two read masters share one AXI4-Lite slave. Arbitration is round-robin on the AR channel. Because AXI4-Lite carries no IDs, a grant-order FIFO routes each R beat back to the master that issued the matching address. The block sits upstream of a slave port or upstream of an address splitter, as the merge counterpart to the read-side bus split.

---
 rtl/axi4_lite_rd_arbiter.sv | 139 +++++++++++++
 tb/tb_axi4_lite_rd_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_rd_arbiter.sv
// Two-to-one AXI4-Lite read arbiter: round-robin AR grant, grant-order FIFO routes R beats back.
// Define AXI4_LITE_RD_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module axi4_lite_rd_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic                  aclk,
  input  logic                  areset,
  // requester ports, index i occupies slice [i*W +: W]
  input  logic [1:0]            s_arvalid,
  output logic [1:0]            s_arready,
  input  logic [2*ADDR_W-1:0]   s_araddr,
  input  logic [5:0]            s_arprot,
  output logic [1:0]            s_rvalid,
  input  logic [1:0]            s_rready,
  output logic [2*DATA_W-1:0]   s_rdata,
  output logic [3:0]            s_rresp,
  output logic [1:0]            s_awready,
  output logic [1:0]            s_wready,
  output logic [1:0]            s_bvalid,
  // shared downstream port
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [ADDR_W-1:0]     m_araddr,
  output logic [2:0]            m_arprot,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic [1:0]            m_rresp,
  output logic                  m_awvalid,
  output logic                  m_wvalid,
  output logic                  m_bready
);

  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);
  localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUT);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUT - 1);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_ADDR = 1'b1;

  logic               state_q, state_d;
  logic               grant_q, grant_d;
  logic [MAX_OUT-1:0] fifo_q;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               ar_hs, r_hs, nonempty, head, pick;

  assign s_awready = '0;
  assign s_wready  = '0;
  assign s_bvalid  = '0;
  assign m_awvalid = 1'b0;
  assign m_wvalid  = 1'b0;
  assign m_bready  = 1'b0;

`ifdef AXI4_LITE_RD_ARB_FIXED_PRIO_EN
  assign pick = ~s_arvalid[0];
`else
  logic rr_ptr_q;
  assign pick = (&s_arvalid) ? rr_ptr_q : s_arvalid[1];

  always_ff @(posedge aclk) begin
    if (areset) begin
      rr_ptr_q <= 1'b0;
    end else if (ar_hs) begin
      rr_ptr_q <= ~grant_q;
    end
  end
`endif

  assign nonempty = (count_q != '0);
  assign head     = fifo_q[rd_ptr_q];
  assign ar_hs    = (state_q == ST_ADDR) & m_arvalid & m_arready;
  assign r_hs     = m_rvalid & m_rready;

  // R data is broadcast; only the head requester sees rvalid.
  assign s_rdata = {2{m_rdata}};
  assign s_rresp = {2{m_rresp}};

  always_comb begin
    m_arvalid = 1'b0;
    s_arready = '0;
    m_araddr  = grant_q ? s_araddr[2*ADDR_W-1:ADDR_W] : s_araddr[ADDR_W-1:0];
    m_arprot  = grant_q ? s_arprot[5:3] : s_arprot[2:0];
    if (state_q == ST_ADDR) begin
      m_arvalid          = s_arvalid[grant_q];
      s_arready[grant_q] = m_arready;
    end
    s_rvalid       = '0;
    s_rvalid[head] = m_rvalid & nonempty;
    m_rready       = s_rready[head] & nonempty;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: begin
        if ((|s_arvalid) && (count_q < CNT_MAX)) begin
          grant_d = pick;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (ar_hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= ST_IDLE;
      grant_q  <= 1'b0;
      fifo_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      if (ar_hs) begin
        fifo_q[wr_ptr_q] <= grant_q;
        wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (r_hs) begin
        rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({ar_hs, r_hs})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_rd_arbiter.sv
// Directed self-checking bench for axi4_lite_rd_arbiter (MAX_OUT = 4, 32-bit address/data).
module tb_axi4_lite_rd_arbiter;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [1:0]  s_arvalid = '0;
  logic [1:0]  s_arready;
  logic [63:0] s_araddr = '0;
  logic [5:0]  s_arprot = '0;
  logic [1:0]  s_rvalid;
  logic [1:0]  s_rready = '0;
  logic [63:0] s_rdata;
  logic [3:0]  s_rresp;
  logic [1:0]  s_awready, s_wready, s_bvalid;
  logic        m_arvalid;
  logic        m_arready = 1'b0;
  logic [31:0] m_araddr;
  logic [2:0]  m_arprot;
  logic        m_rvalid = 1'b0;
  logic        m_rready;
  logic [31:0] m_rdata = '0;
  logic [1:0]  m_rresp = '0;
  logic        m_awvalid, m_wvalid, m_bready;

  int total = 0;
  int bad   = 0;
  logic mon_en = 1'b0;
  logic seen_r1 = 1'b0;

  axi4_lite_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUT(4)) dut (
    .aclk(aclk), .areset(areset),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_awready(s_awready), .s_wready(s_wready), .s_bvalid(s_bvalid),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_awvalid(m_awvalid), .m_wvalid(m_wvalid), .m_bready(m_bready)
  );

  always #5 aclk = ~aclk;

  always @(negedge aclk) if (mon_en && s_rvalid[1]) seen_r1 = 1'b1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #2;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    s_arvalid = '0; m_arready = 1'b0; m_rvalid = 1'b0; s_rready = '0;
    step();
    step();
    areset = 1'b0;
  endtask

  // Issue one read from requester m and wait (bounded) for its downstream AR handshake.
  task automatic do_ar(input int m, input logic [31:0] addr, output int who);
    logic hit;
    hit = 1'b0;
    who = -1;
    s_arvalid = '0;
    s_arvalid[m] = 1'b1;
    if (m == 0) s_araddr[31:0] = addr; else s_araddr[63:32] = addr;
    m_arready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (m_arvalid && m_arready) begin
        hit = 1'b1;
        who = s_arready[1] ? 1 : 0;
        chk("ar_addr", m_araddr, addr);
      end
      step();
      if (hit) break;
    end
    s_arvalid = '0;
    m_arready = 1'b0;
    if (!hit) chk("ar_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int who;
    int n;
    int g[4];

    // Reset state
    do_reset();
    #1;
    chk("rst_m_arvalid", 32'(m_arvalid), 32'd0);
    chk("rst_m_rready", 32'(m_rready), 32'd0);
    chk("rst_s_arready", 32'(s_arready), 32'd0);
    chk("rst_s_rvalid", 32'(s_rvalid), 32'd0);
    chk("rst_count", 32'(dut.count_q), 32'd0);
    chk("tieoff_m", 32'({m_awvalid, m_wvalid, m_bready}), 32'd0);
    chk("tieoff_s", 32'({s_awready, s_wready, s_bvalid}), 32'd0);

    // Single master read of 0x10, data 0xA5 after 3 cycles
    step();
    mon_en = 1'b1; seen_r1 = 1'b0;
    s_arvalid = 2'b01; s_araddr[31:0] = 32'h10;
    #1;
    chk("single_idle_arvalid", 32'(m_arvalid), 32'd0);
    step();
    chk("single_arvalid", 32'(m_arvalid), 32'd1);
    chk("single_araddr", m_araddr, 32'h10);
    m_arready = 1'b1;
    #1;
    chk("single_arready", 32'(s_arready), 32'b01);
    step();
    s_arvalid = '0; m_arready = 1'b0;
    step(); step(); step();
    m_rvalid = 1'b1; m_rdata = 32'hA5; s_rready = 2'b11;
    #1;
    chk("single_rvalid", 32'(s_rvalid), 32'b01);
    chk("single_rdata", s_rdata[31:0], 32'hA5);
    step();
    m_rvalid = 1'b0;
    #1;
    chk("single_count", 32'(dut.count_q), 32'd0);
    chk("single_no_r1", 32'(seen_r1), 32'd0);
    mon_en = 1'b0;

    // Contention: both hold arvalid, arready and R always accepted
    do_reset();
    s_arvalid = 2'b11; m_arready = 1'b1; m_rvalid = 1'b1; s_rready = 2'b11;
    n = 0;
    for (int i = 0; i < 30 && n < 4; i++) begin
      #1;
      if (m_arvalid && m_arready) begin
        g[n] = s_arready[1] ? 1 : 0;
        n++;
      end
      step();
    end
    chk("cont_count", n, 4);
    for (int i = 0; i < 4; i++) begin
`ifdef AXI4_LITE_RD_ARB_FIXED_PRIO_EN
      chk($sformatf("cont_grant%0d", i), g[i], 0);
`else
      chk($sformatf("cont_grant%0d", i), g[i], i % 2);
`endif
    end

    // Ordering: 0->0x0, 1->0x4, 0->0x8; responses 0x11, 0x22, 0x33
    do_reset();
    do_ar(0, 32'h0, who); chk("ord_g0", who, 0);
    do_ar(1, 32'h4, who); chk("ord_g1", who, 1);
    do_ar(0, 32'h8, who); chk("ord_g2", who, 0);
    s_rready = 2'b11; m_rvalid = 1'b1;
    m_rdata = 32'h11; #1;
    chk("ord_rv0", 32'(s_rvalid), 32'b01);
    chk("ord_d0", s_rdata[31:0], 32'h11);
    step();
    m_rdata = 32'h22; #1;
    chk("ord_rv1", 32'(s_rvalid), 32'b10);
    chk("ord_d1", s_rdata[63:32], 32'h22);
    step();
    m_rdata = 32'h33; #1;
    chk("ord_rv2", 32'(s_rvalid), 32'b01);
    chk("ord_d2", s_rdata[31:0], 32'h33);
    step();
    m_rvalid = 1'b0;

    // Full: slave withholds R, exactly MAX_OUT grants
    do_reset();
    s_arvalid = 2'b01; m_arready = 1'b1;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (m_arvalid && m_arready) n++;
      step();
    end
    #1;
    chk("full_hs", n, 4);
    chk("full_arready", 32'(s_arready), 32'd0);
    chk("full_arvalid", 32'(m_arvalid), 32'd0);
    chk("full_count", 32'(dut.count_q), 32'd4);
    m_rvalid = 1'b1; m_rdata = 32'h5A; s_rready = 2'b01;
    #1;
    chk("full_rready", 32'(m_rready), 32'd1);
    step();
    m_rvalid = 1'b0;
    #1;
    chk("full_no_grant_yet", 32'(m_arvalid), 32'd0);
    step();
    chk("full_regrant", 32'({m_arvalid, s_arready}), 32'b101);
    step();
    s_arvalid = '0; m_arready = 1'b0;
    #1;
    chk("full_count2", 32'(dut.count_q), 32'd4);

    // Backpressure on requester 1, then simultaneous AR and R handshakes
    do_reset();
    do_ar(1, 32'h40, who); chk("bp_g", who, 1);
    m_rvalid = 1'b1; m_rdata = 32'h77; s_rready = 2'b00;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_rready", 32'({m_rready, s_rvalid}), 32'b010);
      step();
    end
    s_rready = 2'b10;
    #1;
    chk("bp_release", 32'(m_rready), 32'd1);
    chk("bp_data", s_rdata[63:32], 32'h77);
    step();
    m_rvalid = 1'b0; s_rready = 2'b00;
    #1;
    chk("bp_count", 32'(dut.count_q), 32'd0);
    step();
    do_ar(0, 32'h80, who);
    s_arvalid = 2'b10; s_araddr[63:32] = 32'h84; m_arready = 1'b1;
    step();
    m_rvalid = 1'b1; m_rdata = 32'h99; s_rready = 2'b11;
    #1;
    chk("sim_both_hs", 32'({m_arvalid & m_arready, m_rready}), 32'b11);
    step();
    s_arvalid = '0; m_arready = 1'b0;
    #1;
    chk("sim_count", 32'(dut.count_q), 32'd1);
    chk("sim_head1", 32'(s_rvalid), 32'b10);
    step();
    m_rvalid = 1'b0; s_rready = 2'b00;

    // Reset with 3 reads outstanding
    do_reset();
    do_ar(0, 32'h0, who);
    do_ar(1, 32'h4, who);
    do_ar(0, 32'h8, who);
    m_rvalid = 1'b1;
    areset = 1'b1;
    step();
    areset = 1'b0;
    #1;
    chk("mid_rst_count", 32'(dut.count_q), 32'd0);
    chk("mid_rst_valids", 32'({m_arvalid, m_rready, s_arready, s_rvalid}), 32'd0);
    s_arvalid = 2'b11; m_arready = 1'b1; m_rvalid = 1'b0;
    step();
    chk("mid_rst_grant0", 32'(s_arready), 32'b01);
    step();
    s_arvalid = '0; m_arready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
